wport_arbiter: RTL and testbench

WPORT_ARBITER -- requirements
Module: wport_arbiter

---
 rtl/wport_pkg.sv | 20 ++
 rtl/wport_mux2.sv | 30 +++
 rtl/wport_arbiter.sv | 108 ++++++++++
 tb/tb_wport_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/wport_pkg.sv
// Shared definitions for the two-requester register-file write-port arbiter.
// No logic: FSM state encodings, mux select constants and a small helper.
// Imported by the arbiter top and the write-port mux.
package wport_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } state_t;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    // Grant target when both requesters collide in IDLE: whoever was not served last.
    function automatic state_t pick_contended(input logic last_sel);
        return (last_sel == SEL_A) ? GNT_B : GNT_A;
    endfunction

endpackage

// File: rtl/wport_mux2.sv
// Write-port mux: steers address and data of requester A or B to the register file.
// Latency: purely combinational, zero cycles.
// Backpressure: none, follows sel every cycle.
module wport_mux2
    import wport_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          sel,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] data0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] data1,
    output logic [AW-1:0] addr,
    output logic [DW-1:0] data
);

    // Address and data always switch together so a write never mixes requesters.
    always_comb begin
        if (sel == SEL_B) begin
            addr = addr1;
            data = data1;
        end else begin
            addr = addr0;
            data = data0;
        end
    end

endmodule

// File: rtl/wport_arbiter.sv
// Arbitrates two write requesters onto one register-file write port, round-robin on collision.
// Latency: ack one cycle after req is sampled in IDLE; back-to-back alternating grants under contention.
// Backpressure: requesters hold req/addr/data until ack; the granted req is ignored during its own grant.
module wport_arbiter
    import wport_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          req_a,
    input  logic          req_b,
    input  logic [AW-1:0] addr_a,
    input  logic [AW-1:0] addr_b,
    input  logic [DW-1:0] data_a,
    input  logic [DW-1:0] data_b,
    output logic          ack_a,
    output logic          ack_b,
    output logic          wsel,
    output logic          regwe,
    output logic [AW-1:0] waddr,
    output logic [DW-1:0] wdata,
    output logic [7:0]    wr_count
);

    state_t     state;
    state_t     state_nxt;
    logic       last_sel;
    logic       wsel_q;
    logic       ack_a_q;
    logic       ack_b_q;
    logic [7:0] cnt_q;
    logic       in_grant;

    // Next grant: the requester just served is skipped, so its still-high req is not re-granted.
    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE: begin
                if (req_a && req_b) begin
                    state_nxt = pick_contended(last_sel);
                end else if (req_a) begin
                    state_nxt = GNT_A;
                end else if (req_b) begin
                    state_nxt = GNT_B;
                end else begin
                    state_nxt = IDLE;
                end
            end
            GNT_A:   state_nxt = req_b ? GNT_B : IDLE;
            GNT_B:   state_nxt = req_a ? GNT_A : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM with registered select/acks; the pointer and select move on entry to a grant.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            wsel_q   <= SEL_A;
            last_sel <= SEL_B;
            ack_a_q  <= 1'b0;
            ack_b_q  <= 1'b0;
            cnt_q    <= 8'd0;
        end else begin
            state   <= state_nxt;
            ack_a_q <= (state_nxt == GNT_A);
            ack_b_q <= (state_nxt == GNT_B);
            if (state_nxt == GNT_A) begin
                wsel_q   <= SEL_A;
                last_sel <= SEL_A;
            end else if (state_nxt == GNT_B) begin
                wsel_q   <= SEL_B;
                last_sel <= SEL_B;
            end
            if (regwe) begin
                cnt_q <= cnt_q + 8'd1;
            end
        end
    end

    wport_mux2 #(
        .DW(DW),
        .AW(AW)
    ) u_mux (
        .sel   (wsel_q),
        .addr0 (addr_a),
        .data0 (data_a),
        .addr1 (addr_b),
        .data1 (data_b),
        .addr  (waddr),
        .data  (wdata)
    );

    // Strobes come from registered state only; reset masks them immediately, and
    // a write to register 0 is acknowledged but never enabled.
    always_comb begin
        in_grant = (state == GNT_A) || (state == GNT_B);
        ack_a    = reset_n && ack_a_q;
        ack_b    = reset_n && ack_b_q;
        regwe    = reset_n && in_grant && (waddr != '0);
    end

    assign wsel     = wsel_q;
    assign wr_count = cnt_q;

endmodule

// File: tb/tb_wport_arbiter.sv
// Self-checking bench for wport_arbiter: directed scenarios plus randomized requesters.
// Expected values come from a transaction-level model of who is granted each cycle.
// Requesters obey the hold-until-ack protocol.
module tb_wport_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          req_a = 1'b0;
    logic          req_b = 1'b0;
    logic [AW-1:0] addr_a = '0;
    logic [AW-1:0] addr_b = '0;
    logic [DW-1:0] data_a = '0;
    logic [DW-1:0] data_b = '0;
    logic          ack_a;
    logic          ack_b;
    logic          wsel;
    logic          regwe;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic [7:0]    wr_count;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: who holds the port this cycle (0 none, 1 A, 2 B), who was served last,
    // where the mux points, and how many writes have committed.
    int m_gnt  = 0;
    int m_last = 2;
    int m_wsel = 0;
    int m_cnt  = 0;

    always #5 clk = ~clk;

    wport_arbiter #(.DW(DW), .AW(AW)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req_a    (req_a),
        .req_b    (req_b),
        .addr_a   (addr_a),
        .addr_b   (addr_b),
        .data_a   (data_a),
        .data_b   (data_b),
        .ack_a    (ack_a),
        .ack_b    (ack_b),
        .wsel     (wsel),
        .regwe    (regwe),
        .waddr    (waddr),
        .wdata    (wdata),
        .wr_count (wr_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [AW-1:0] sel_addr();
        return (m_wsel == 1) ? addr_b : addr_a;
    endfunction

    function automatic logic [DW-1:0] sel_data();
        return (m_wsel == 1) ? data_b : data_a;
    endfunction

    // One clock: predict from current inputs, advance, then compare every output.
    task automatic step();
        int n_gnt;
        int n_cnt;
        n_cnt = m_cnt;
        n_gnt = 0;
        if (!reset_n) begin
            n_gnt  = 0;
            n_cnt  = 0;
        end else begin
            if (m_gnt != 0 && sel_addr() != 0) n_cnt = (m_cnt + 1) % 256;
            if (m_gnt == 1)      n_gnt = req_b ? 2 : 0;
            else if (m_gnt == 2) n_gnt = req_a ? 1 : 0;
            else if (req_a && req_b) n_gnt = (m_last == 1) ? 2 : 1;
            else if (req_a)      n_gnt = 1;
            else if (req_b)      n_gnt = 2;
        end
        @(posedge clk);
        #1;
        if (!reset_n) begin
            m_last = 2;
            m_wsel = 0;
        end else if (n_gnt != 0) begin
            m_last = n_gnt;
            m_wsel = n_gnt - 1;
        end
        m_gnt = n_gnt;
        m_cnt = n_cnt;
        chk("ack_a",    32'(ack_a),    32'(reset_n && m_gnt == 1));
        chk("ack_b",    32'(ack_b),    32'(reset_n && m_gnt == 2));
        chk("wsel",     32'(wsel),     32'(m_wsel));
        chk("regwe",    32'(regwe),    32'(reset_n && m_gnt != 0 && sel_addr() != 0));
        chk("waddr",    32'(waddr),    32'(sel_addr()));
        chk("wdata",    32'(wdata),    32'(sel_data()));
        chk("wr_count", 32'(wr_count), 32'(m_cnt));
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req_a   = 1'b0;
        req_b   = 1'b0;
        step();
        reset_n = 1'b1;
    endtask

    task automatic new_a();
        addr_a = ($urandom_range(7, 0) == 0) ? '0 : AW'($urandom);
        data_a = $urandom;
    endtask

    task automatic new_b();
        addr_b = ($urandom_range(7, 0) == 0) ? '0 : AW'($urandom);
        data_b = $urandom;
    endtask

    initial begin
        // Reset state
        do_reset();
        step();
        chk("rst_ack_a", 32'(ack_a), 32'd0);
        chk("rst_wsel",  32'(wsel),  32'd0);
        chk("rst_cnt",   32'(wr_count), 32'd0);

        // Single write from A
        reset_n = 1'b1;
        req_a = 1'b1; addr_a = 5'd3; data_a = 32'hDEADBEEF;
        step();
        chk("a1_ack",   32'(ack_a), 32'd1);
        chk("a1_wsel",  32'(wsel),  32'd0);
        chk("a1_regwe", 32'(regwe), 32'd1);
        chk("a1_waddr", 32'(waddr), 32'd3);
        chk("a1_wdata", 32'(wdata), 32'hDEADBEEF);
        req_a = 1'b0;
        step();
        chk("a1_cnt",   32'(wr_count), 32'd1);
        chk("a1_ackoff", 32'(ack_a), 32'd0);

        // Simultaneous first requests: A then B, one-cycle acks
        do_reset();
        req_a = 1'b1; addr_a = 5'd7; data_a = 32'h1111_0001;
        req_b = 1'b1; addr_b = 5'd9; data_b = 32'h2222_0002;
        step();
        chk("sim_first_a", 32'(ack_a), 32'd1);
        chk("sim_first_b", 32'(ack_b), 32'd0);
        req_a = 1'b0;
        step();
        chk("sim_then_b", 32'(ack_b), 32'd1);
        chk("sim_a_off",  32'(ack_a), 32'd0);
        req_b = 1'b0;
        step();
        chk("sim_b_off",  32'(ack_b), 32'd0);

        // Continuous contention for 6 cycles alternates and commits 6 writes
        do_reset();
        req_a = 1'b1; req_b = 1'b1; addr_a = 5'd4; addr_b = 5'd5;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("alt_a", 32'(ack_a), 32'(i % 2 == 0));
            chk("alt_b", 32'(ack_b), 32'(i % 2 == 1));
        end
        req_a = 1'b0; req_b = 1'b0;
        step();
        chk("alt_cnt", 32'(wr_count), 32'd6);

        // Write to register 0 is acknowledged but suppressed
        do_reset();
        req_b = 1'b1; addr_b = '0; data_b = 32'hCAFE_F00D;
        step();
        chk("r0_ack",   32'(ack_b), 32'd1);
        chk("r0_regwe", 32'(regwe), 32'd0);
        req_b = 1'b0;
        step();
        chk("r0_cnt",   32'(wr_count), 32'd0);

        // Reset during GNT_A aborts the grant; A still wins first afterwards
        do_reset();
        req_a = 1'b1; req_b = 1'b1; addr_a = 5'd1; addr_b = 5'd2;
        step();
        chk("ab_gnt_a", 32'(ack_a), 32'd1);
        reset_n = 1'b0;
        step();
        chk("ab_ack_a", 32'(ack_a), 32'd0);
        chk("ab_ack_b", 32'(ack_b), 32'd0);
        chk("ab_cnt",   32'(wr_count), 32'd0);
        reset_n = 1'b1;
        step();
        chk("ab_ack_a", 32'(ack_a), 32'd1);
        step();
        chk("ab_then_b", 32'(ack_b), 32'd1);

        // 256 committed writes wrap the counter
        do_reset();
        req_a = 1'b1; req_b = 1'b1; addr_a = 5'd10; addr_b = 5'd20;
        for (int i = 0; i < 257; i++) step();
        chk("wrap_cnt", 32'(wr_count), 32'd0);

        // Randomized requesters with occasional reset pulses
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            reset_n = ($urandom_range(59, 0) != 0);
            step();
            if (req_a && m_gnt == 1) begin
                if ($urandom_range(1, 0) == 0) req_a = 1'b0;
                else new_a();
            end else if (!req_a && $urandom_range(9, 0) < 6) begin
                req_a = 1'b1;
                new_a();
            end
            if (req_b && m_gnt == 2) begin
                if ($urandom_range(1, 0) == 0) req_b = 1'b0;
                else new_b();
            end else if (!req_b && $urandom_range(9, 0) < 6) begin
                req_b = 1'b1;
                new_b();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
